// File: rtl/virtual_input_ctrl.sv
// virtual_input_ctrl
//   Drives a bank of virtual push-buttons and slide switches from a simple
//   asynchronous command port. A rising edge on control issues one command
//   that acts on the channel selected by number, using opcode op.
//
// Ports
//   clk, reset           : system clock, asynchronous active-high reset
//   control              : async command strobe (rising edge = command)
//   number [IDX_W-1:0]   : channel index (buttons first, then switches)
//   op [1:0]             : 00 toggle, 01 set-to-value, 10 pulse, 11 clear-all
//   value                : data bit for set-to-value; also mirrored on led_control
//   buttons              : active-low virtual buttons (1 = released)
//   switches             : active-high virtual switches (1 = on)
//   led_control          : synchronized copy of value
//   busy                 : high while a pulse press is in progress
//   err                  : one-cycle pulse on a rejected command
module virtual_input_ctrl #(
  parameter int unsigned NUM_BUTTONS  = 4,
  parameter int unsigned NUM_SWITCHES = 18,
  parameter int unsigned IDX_W        = 5,
  parameter int unsigned PULSE_CYCLES = 5000000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    control,
  input  logic [IDX_W-1:0]        number,
  input  logic [1:0]              op,
  input  logic                    value,
  output logic [NUM_BUTTONS-1:0]  buttons,
  output logic [NUM_SWITCHES-1:0] switches,
  output logic                    led_control,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned NUM_CH = NUM_BUTTONS + NUM_SWITCHES;
  localparam int unsigned CNT_W  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_PULSE  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    PRESS = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  ctrl_sync_q, ctrl_sync_d;
  logic [SYNC_STAGES-1:0]  val_sync_q, val_sync_d;
  logic [SYNC_STAGES-1:0]  vld_sync_q, vld_sync_d;
  logic                    ctrl_prev_q, ctrl_prev_d;
  logic                    armed_q, armed_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0]  buttons_q, buttons_d;
  logic [NUM_BUTTONS-1:0]  press_mask_q, press_mask_d;
  logic [NUM_SWITCHES-1:0] switches_q, switches_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic                    ctrl_s;
  logic                    val_s;
  logic                    vld_s;
  logic                    cmd_fire;
  logic [31:0]             num_ext;
  logic                    num_valid;
  logic                    num_is_btn;
  logic [NUM_BUTTONS-1:0]  btn_sel;
  logic [NUM_SWITCHES-1:0] sw_sel;

  assign ctrl_s = ctrl_sync_q[SYNC_STAGES-1];
  assign val_s  = val_sync_q[SYNC_STAGES-1];
  assign vld_s  = vld_sync_q[SYNC_STAGES-1];

  // Rising edge of synchronized control; armed only after a genuine low has been
  // seen, so a strobe held high across reset release issues nothing.
  assign cmd_fire = armed_q & ctrl_s & ~ctrl_prev_q;

  // Channel decode: index k -> buttons[NB-1-k], index NB+j -> switches[NS-1-j]
  always_comb begin
    num_ext    = 32'(number);
    num_valid  = (num_ext < NUM_CH);
    num_is_btn = (num_ext < NUM_BUTTONS);
    btn_sel    = '0;
    sw_sel     = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      btn_sel[i] = (num_ext == (NUM_BUTTONS - 1 - i));
    end
    for (int unsigned i = 0; i < NUM_SWITCHES; i++) begin
      sw_sel[i] = (num_ext == (NUM_CH - 1 - i));
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    ctrl_sync_d  = {ctrl_sync_q[SYNC_STAGES-2:0], control};
    val_sync_d   = {val_sync_q[SYNC_STAGES-2:0], value};
    vld_sync_d   = {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
    ctrl_prev_d  = ctrl_s;
    armed_d      = armed_q | (vld_s & ~ctrl_s);
    cnt_d        = cnt_q;
    buttons_d    = buttons_q;
    press_mask_d = press_mask_q;
    switches_d   = switches_q;
    err_d        = 1'b0;

    // Pulse timing runs independently of any rejected command
    if (state_q == PRESS) begin
      if (cnt_q == CNT_LAST) begin
        state_d      = IDLE;
        cnt_d        = '0;
        buttons_d    = buttons_q | press_mask_q;
        press_mask_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (cmd_fire) begin
      if (op == OP_CLEAR) begin
        state_d      = IDLE;
        cnt_d        = '0;
        buttons_d    = '1;
        switches_d   = '0;
        press_mask_d = '0;
      end else if (state_q == PRESS || !num_valid) begin
        err_d = 1'b1;
      end else begin
        unique case (op)
          OP_TOGGLE: begin
            buttons_d  = buttons_q ^ btn_sel;
            switches_d = switches_q ^ sw_sel;
          end
          OP_SET: begin
            buttons_d  = (buttons_q & ~btn_sel) | (btn_sel & {NUM_BUTTONS{val_s}});
            switches_d = (switches_q & ~sw_sel) | (sw_sel & {NUM_SWITCHES{val_s}});
          end
          OP_PULSE: begin
            if (num_is_btn) begin
              state_d      = PRESS;
              cnt_d        = '0;
              buttons_d    = buttons_q & ~btn_sel;
              press_mask_d = btn_sel;
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end

    busy_d = (state_d == PRESS);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ctrl_sync_q  <= '0;
      val_sync_q   <= '0;
      vld_sync_q   <= '0;
      ctrl_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      buttons_q    <= '1;
      press_mask_q <= '0;
      switches_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_sync_q  <= ctrl_sync_d;
      val_sync_q   <= val_sync_d;
      vld_sync_q   <= vld_sync_d;
      ctrl_prev_q  <= ctrl_prev_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      buttons_q    <= buttons_d;
      press_mask_q <= press_mask_d;
      switches_q   <= switches_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign buttons     = buttons_q;
  assign switches    = switches_q;
  assign led_control = val_s;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_virtual_input_ctrl.sv
// Directed bench for virtual_input_ctrl with a short pulse length.
module tb_virtual_input_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned NS = 18;
  localparam int unsigned IW = 5;
  localparam int unsigned PC = 4;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          control;
  logic [IW-1:0] number;
  logic [1:0]    op;
  logic          value;
  logic [NB-1:0] buttons;
  logic [NS-1:0] switches;
  logic          led_control;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  virtual_input_ctrl #(
    .NUM_BUTTONS (NB),
    .NUM_SWITCHES(NS),
    .IDX_W       (IW),
    .PULSE_CYCLES(PC),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .control    (control),
    .number     (number),
    .op         (op),
    .value      (value),
    .buttons    (buttons),
    .switches   (switches),
    .led_control(led_control),
    .busy       (busy),
    .err        (err)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge after the output update edge
  task automatic issue(input logic [IW-1:0] n, input logic [1:0] o, input logic v);
    number  = n;
    op      = o;
    value   = v;
    control = 1'b1;
    tick(1);
    control = 1'b0;
    tick(2);
  endtask

  initial begin
    reset   = 1'b1;
    control = 1'b0;
    number  = '0;
    op      = 2'b00;
    value   = 1'b0;
    tick(3);
    chk("rst_buttons", 32'(buttons), 32'h0000_000F);
    chk("rst_switches", 32'(switches), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_led", 32'(led_control), 32'h0);
    reset = 1'b0;
    tick(4);

    // Toggle switch index 4 with latency check, then toggle back
    number  = 5'd4;
    op      = 2'b00;
    control = 1'b1;
    tick(1);
    chk("lat_e0_sw", 32'(switches), 32'h0);
    tick(1);
    chk("lat_e1_sw", 32'(switches), 32'h0);
    tick(1);
    chk("lat_e2_sw", 32'(switches), 32'h0002_0000);
    chk("lat_e2_err", 32'(err), 32'h0);
    chk("lat_e2_btn", 32'(buttons), 32'h0000_000F);
    control = 1'b0;
    tick(3);
    issue(5'd4, 2'b00, 1'b0);
    chk("tog_back_sw", 32'(switches), 32'h0);
    chk("tog_back_btn", 32'(buttons), 32'h0000_000F);

    // Pulse on index 0 with a rejected toggle during the press
    issue(5'd0, 2'b10, 1'b0);
    chk("pulse_start_btn", 32'(buttons), 32'h0000_0007);
    chk("pulse_start_busy", 32'(busy), 32'h1);
    issue(5'd5, 2'b00, 1'b0);
    chk("press_rej_err", 32'(err), 32'h1);
    chk("press_rej_btn", 32'(buttons), 32'h0000_0007);
    chk("press_rej_busy", 32'(busy), 32'h1);
    chk("press_rej_sw", 32'(switches), 32'h0);
    tick(1);
    chk("pulse_end_btn", 32'(buttons), 32'h0000_000F);
    chk("pulse_end_busy", 32'(busy), 32'h0);
    chk("pulse_end_err", 32'(err), 32'h0);
    chk("pulse_end_sw", 32'(switches), 32'h0);

    // Out-of-range index and pulse on a switch
    issue(5'd22, 2'b00, 1'b0);
    chk("oor_err", 32'(err), 32'h1);
    chk("oor_sw", 32'(switches), 32'h0);
    chk("oor_btn", 32'(buttons), 32'h0000_000F);
    tick(1);
    chk("oor_err_clr", 32'(err), 32'h0);
    issue(5'd6, 2'b10, 1'b0);
    chk("swpulse_err", 32'(err), 32'h1);
    chk("swpulse_busy", 32'(busy), 32'h0);
    chk("swpulse_sw", 32'(switches), 32'h0);
    chk("swpulse_btn", 32'(buttons), 32'h0000_000F);
    tick(1);
    chk("swpulse_err_clr", 32'(err), 32'h0);

    // Boundary indices: last switch and last button
    issue(5'd21, 2'b00, 1'b0);
    chk("idx21_sw", 32'(switches), 32'h0000_0001);
    chk("idx21_err", 32'(err), 32'h0);
    issue(5'd3, 2'b00, 1'b0);
    chk("idx3_tog_btn", 32'(buttons), 32'h0000_000E);
    issue(5'd3, 2'b01, 1'b1);
    chk("idx3_set_btn", 32'(buttons), 32'h0000_000F);

    // Set switches[17:15], start pulse on index 1, clear-all mid-press
    issue(5'd4, 2'b01, 1'b1);
    chk("set4_sw", 32'(switches), 32'h0002_0001);
    issue(5'd5, 2'b01, 1'b1);
    chk("set5_sw", 32'(switches), 32'h0003_0001);
    issue(5'd6, 2'b01, 1'b1);
    chk("set6_sw", 32'(switches), 32'h0003_8001);
    chk("led_follow", 32'(led_control), 32'h1);
    issue(5'd1, 2'b10, 1'b1);
    chk("p1_btn", 32'(buttons), 32'h0000_000B);
    chk("p1_busy", 32'(busy), 32'h1);
    issue(5'd9, 2'b11, 1'b1);
    chk("clr_btn", 32'(buttons), 32'h0000_000F);
    chk("clr_sw", 32'(switches), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_err", 32'(err), 32'h0);
    tick(1);
    chk("clr_hold_btn", 32'(buttons), 32'h0000_000F);
    chk("clr_hold_busy", 32'(busy), 32'h0);

    // Held-high control issues exactly one toggle
    number  = 5'd5;
    op      = 2'b00;
    control = 1'b1;
    tick(20);
    chk("hold_one_sw", 32'(switches), 32'h0001_0000);
    control = 1'b0;
    tick(3);

    // Reset mid-pulse with control high; no command until control re-toggles
    issue(5'd2, 2'b10, 1'b1);
    chk("p2_btn", 32'(buttons), 32'h0000_000D);
    chk("p2_busy", 32'(busy), 32'h1);
    number  = 5'd5;
    op      = 2'b00;
    control = 1'b1;
    tick(1);
    reset = 1'b1;
    #1;
    chk("rst_mid_btn", 32'(buttons), 32'h0000_000F);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_sw", 32'(switches), 32'h0);
    chk("rst_mid_led", 32'(led_control), 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(8);
    chk("post_rst_sw", 32'(switches), 32'h0);
    chk("post_rst_err", 32'(err), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    control = 1'b0;
    tick(3);
    control = 1'b1;
    tick(3);
    chk("retoggle_sw", 32'(switches), 32'h0001_0000);
    control = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/virtual_input_ctrl.md
VIRTUAL_INPUT_CTRL -- requirements
Module: virtual_input_ctrl

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, 4, number of active-low virtual push-buttons.
REQ-002 SHALL have parameter NUM_SWITCHES, 18, number of active-high virtual slide switches.
REQ-003 SHALL have parameter IDX_W, 5, width of the channel index; NUM_BUTTONS+NUM_SWITCHES <= 2**IDX_W.
REQ-004 SHALL have parameter PULSE_CYCLES, 5000000, press duration of a pulse command in clk cycles (>=1).
REQ-005 SHALL have parameter SYNC_STAGES, 2, synchronizer depth for asynchronous inputs (>=2).
REQ-006 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port control  input  1  asynchronous command strobe; rising edge issues a command.
REQ-009 SHALL have port number  input  IDX_W  channel index of the command.
REQ-010 SHALL have port op  input  2  opcode: 00 toggle, 01 set-to-value, 10 pulse, 11 clear-all.
REQ-011 SHALL have port value  input  1  data bit for op 01; also drives led_control.
REQ-012 SHALL have port buttons  output  NUM_BUTTONS  virtual buttons, 1 = released.
REQ-013 SHALL have port switches  output  NUM_SWITCHES  virtual switches, 1 = on.
REQ-014 SHALL have port led_control  output  1  synchronized copy of value.
REQ-015 SHALL have port busy  output  1  high while a pulse press is in progress.
REQ-016 SHALL have port err  output  1  one-cycle pulse on a rejected command.

Function
REQ-017 control and value SHALL each pass through SYNC_STAGES flops; number and op SHALL be sampled on the cycle the edge is detected (source holds them stable >= SYNC_STAGES+2 cycles around the strobe).
REQ-018 A command SHALL be detected when the synchronized control is 1 and its previous-cycle value was 0; a held-high control issues exactly one command.
REQ-019 Outputs SHALL update on the clk edge following detection: latency SYNC_STAGES+1 clk edges from control sampled high to output change.
REQ-020 Index k < NUM_BUTTONS SHALL address buttons[NUM_BUTTONS-1-k]; index NUM_BUTTONS+j, j < NUM_SWITCHES, SHALL address switches[NUM_SWITCHES-1-j].
REQ-021 Index >= NUM_BUTTONS+NUM_SWITCHES with op 00/01/10 SHALL change no output and SHALL pulse err.
REQ-022 Op 00 SHALL invert the addressed bit; op 01 SHALL load it with the synchronized value; all other bits hold.
REQ-023 Op 10 on a button SHALL drive it 0, enter state PRESS, assert busy, hold 0 for exactly PULSE_CYCLES cycles, then drive it 1 and return to IDLE.
REQ-024 Op 10 addressing a switch SHALL be rejected: no change, err pulse.
REQ-025 Op 11 SHALL set all buttons to 1, all switches to 0, regardless of number, from any state; in PRESS it SHALL abort the pulse, clear busy and return to IDLE in the same cycle.
REQ-026 FSM states SHALL be IDLE and PRESS only; IDLE->PRESS on accepted op 10; PRESS->IDLE on count expiry or op 11.
REQ-027 In PRESS, any command other than op 11 SHALL be rejected: no change, err pulse, pulse timing unaffected.
REQ-028 Pulse counter SHALL be wide enough for PULSE_CYCLES and SHALL not wrap; it SHALL be cleared on entering IDLE.
REQ-029 err SHALL be high for exactly one cycle per rejected command and low otherwise.
REQ-030 led_control SHALL equal the last synchronizer stage of value, independent of commands.

Reset
REQ-031 While reset is high: buttons all 1, switches all 0, busy 0, err 0, led_control 0, FSM IDLE, counter 0, all synchronizer flops 0.
REQ-032 Reset asserted during PRESS SHALL immediately release the button and clear busy; a control already high at reset release SHALL NOT issue a command until it falls and rises again.

Verification (NUM_BUTTONS=4, NUM_SWITCHES=18, IDX_W=5, PULSE_CYCLES=4, SYNC_STAGES=2)
REQ-033 Reset, then strobe number=4 op=00, then again -> switches[17] 1 after 3 edges, back to 0 after second strobe; buttons stay 4'b1111.
REQ-034 number=0 op=10 -> buttons[3]=0 and busy=1 for exactly 4 cycles, then buttons=4'b1111, busy=0; strobe number=5 op=00 during press -> err one cycle, switches unchanged.
REQ-035 number=22 op=00 and number=6 op=10 -> err one cycle each, no output change.
REQ-036 Set switches[17:15]=1 via op 01 value=1, start pulse on index 1, then op 11 mid-press -> buttons=4'b1111, switches=0, busy=0 next cycle.
REQ-037 Hold control high 20 cycles -> exactly one toggle; assert reset mid-pulse with control high -> outputs at reset values, no command after release until control toggles.
